natv_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one native memory port (valid/ready/addr/wdata/wstrb/rdata, picorv32 mem_* semantics) between NUM_MST requesters, e.g. core and a DMA engine in front of the psram or natv slave path.
- Holds a grant for the whole transaction.
- A per-transaction watchdog completes hung accesses with an error word, so a stuck slave cannot lock the bus.

---
 rtl/natv_arb_pkg.sv | 15 +
 rtl/natv_bus_arbiter_rr_pick.sv | 31 +++
 rtl/natv_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_natv_bus_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/natv_arb_pkg.sv
// Shared types and constants for the native-bus arbiter family.
package natv_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  // Upper bound on the number of requesters an arbiter instance supports.
  localparam int unsigned ARB_MAX_MST = 8;

  // Read data returned when the watchdog forces a transaction to complete.
  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/natv_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping mod NumReq.
module rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  int unsigned cand;

  // Scan ptr+1 .. ptr+NumReq; the modulo keeps non-power-of-two sizes correct.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      cand = (int'(ptr_i) + i) % NumReq;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/natv_bus_arbiter.sv
// Round-robin arbiter sharing one native memory port between NUM_MST masters.
// Grant is held for a whole transaction; a watchdog force-completes hung accesses.
module natv_bus_arbiter
  import natv_arb_pkg::*;
#(
  parameter int unsigned NUM_MST      = 2,
  parameter int unsigned TIMEOUT_CYC  = 1024,
  parameter logic [31:0] TIMEOUT_DATA = ARB_TIMEOUT_DATA
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_MST-1:0]   m_valid_i,
  input  logic [NUM_MST*32-1:0] m_addr_i,
  input  logic [NUM_MST*32-1:0] m_wdata_i,
  input  logic [NUM_MST*4-1:0] m_wstrb_i,
  output logic [31:0]          m_rdata_o,
  output logic [NUM_MST-1:0]   m_ready_o,
  output logic                 s_valid_o,
  output logic [31:0]          s_addr_o,
  output logic [31:0]          s_wdata_o,
  output logic [3:0]           s_wstrb_o,
  input  logic [31:0]          s_rdata_i,
  input  logic                 s_ready_i,
  output logic [NUM_MST-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  localparam int unsigned PtrW  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int unsigned WdogW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic        WdogEn = (TIMEOUT_CYC != 0);
  localparam logic [WdogW-1:0] WdogLast = (TIMEOUT_CYC > 0) ? WdogW'(TIMEOUT_CYC - 1) : '0;

  arb_state_e         state_q, state_d;
  logic [NUM_MST-1:0] grant_q, grant_d;
  logic [PtrW-1:0]    gidx_q, gidx_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [WdogW-1:0]   wdog_q, wdog_d;

  logic [NUM_MST-1:0] pick_gnt;
  logic [PtrW-1:0]    pick_idx;
  logic               pick_any;

  logic busy, g_valid, wdog_hit, done_ok, done_to;

  rr_pick #(
    .NumReq (NUM_MST),
    .IdxW   (PtrW)
  ) u_pick (
    .req_i (m_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Completion decode shared by next-state and output logic.
  always_comb begin
    busy     = (state_q == ARB_BUSY);
    g_valid  = m_valid_i[gidx_q];
    wdog_hit = WdogEn && (wdog_q == WdogLast);
    // s_ready_i in the timeout cycle wins over the watchdog.
    done_ok  = busy && g_valid && s_ready_i;
    done_to  = busy && g_valid && !s_ready_i && wdog_hit;
  end

  // State register with synchronous reset; ptr starts at the last master so master 0 goes first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PtrW'(NUM_MST - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant in BUSY until completion or abort.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_BUSY;
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          wdog_d  = '0;
        end
      end
      ARB_BUSY: begin
        if (!g_valid) begin
          // Master withdrew mid-transaction: abort silently, keep ptr.
          state_d = ARB_IDLE;
          grant_d = '0;
        end else if (done_ok || done_to) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
        end else if (WdogEn) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs: slave side muxed from the granted master; completions gated off during reset.
  always_comb begin
    busy_o    = busy;
    grant_o   = grant_q;
    s_valid_o = busy && g_valid;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_wstrb_o = '0;
    m_ready_o = '0;
    m_rdata_o = '0;
    timeout_o = 1'b0;
    if (busy) begin
      s_addr_o  = m_addr_i[32*gidx_q +: 32];
      s_wdata_o = m_wdata_i[32*gidx_q +: 32];
      s_wstrb_o = m_wstrb_i[4*gidx_q +: 4];
    end
    if (!rst_i) begin
      if (done_ok) begin
        m_ready_o = grant_q;
        m_rdata_o = s_rdata_i;
      end else if (done_to) begin
        m_ready_o = grant_q;
        m_rdata_o = TIMEOUT_DATA;
        timeout_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_natv_bus_arbiter.sv
// Directed bench: two arbiter instances (2 masters with a 16-cycle watchdog, 3 masters).
module tb_natv_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-master instance
  logic [1:0]  mv;
  logic [63:0] ma, mw;
  logic [7:0]  ms;
  logic [31:0] srd;
  logic        srdy;
  logic [31:0] m_rdata, s_addr, s_wdata;
  logic [1:0]  m_ready, grant;
  logic        s_valid, busy, tmo;
  logic [3:0]  s_wstrb;

  // 3-master instance
  logic [2:0]  mv3;
  logic [95:0] ma3, mw3;
  logic [11:0] ms3;
  logic [31:0] srd3;
  logic        srdy3;
  logic [31:0] m_rdata3, s_addr3, s_wdata3;
  logic [2:0]  m_ready3, grant3;
  logic        s_valid3, busy3, tmo3;
  logic [3:0]  s_wstrb3;

  int checks = 0;
  int errors = 0;
  int cnt0, cnt1;
  logic [1:0] exp2;
  logic [2:0] exp3;

  natv_bus_arbiter #(
    .NUM_MST     (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m_valid_i (mv),
    .m_addr_i  (ma),
    .m_wdata_i (mw),
    .m_wstrb_i (ms),
    .m_rdata_o (m_rdata),
    .m_ready_o (m_ready),
    .s_valid_o (s_valid),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_wstrb_o (s_wstrb),
    .s_rdata_i (srd),
    .s_ready_i (srdy),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (tmo)
  );

  natv_bus_arbiter #(
    .NUM_MST     (3),
    .TIMEOUT_CYC (0)
  ) dut3 (
    .clk_i     (clk),
    .rst_i     (rst),
    .m_valid_i (mv3),
    .m_addr_i  (ma3),
    .m_wdata_i (mw3),
    .m_wstrb_i (ms3),
    .m_rdata_o (m_rdata3),
    .m_ready_o (m_ready3),
    .s_valid_o (s_valid3),
    .s_addr_o  (s_addr3),
    .s_wdata_o (s_wdata3),
    .s_wstrb_o (s_wstrb3),
    .s_rdata_i (srd3),
    .s_ready_i (srdy3),
    .grant_o   (grant3),
    .busy_o    (busy3),
    .timeout_o (tmo3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mv = '0; ma = '0; mw = '0; ms = '0; srd = '0; srdy = 1'b0;
    mv3 = '0; ma3 = '0; mw3 = '0; ms3 = '0; srd3 = '0; srdy3 = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_svalid", 32'(s_valid), 32'h0);
    chk("rst_ready", 32'(m_ready), 32'h0);
    chk("rst_timeout", 32'(tmo), 32'h0);
    chk("rst_grant3", 32'(grant3), 32'h0);

    // Single master read, slave ready on the third BUSY cycle.
    mv = 2'b01;
    ma[31:0] = 32'h0400_0010;
    #1;
    chk("t1_idle_grant", 32'(grant), 32'h0);
    step();
    #1;
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_svalid", 32'(s_valid), 32'h1);
    chk("t1_saddr", s_addr, 32'h0400_0010);
    chk("t1_swstrb", 32'(s_wstrb), 32'h0);
    chk("t1_noready1", 32'(m_ready), 32'h0);
    step();
    #1;
    chk("t1_noready2", 32'(m_ready), 32'h0);
    chk("t1_rdata_idle", m_rdata, 32'h0);
    step();
    srdy = 1'b1;
    srd = 32'h1234_5678;
    #1;
    chk("t1_ready", 32'(m_ready), 32'h1);
    chk("t1_rdata", m_rdata, 32'h1234_5678);
    step();
    srdy = 1'b0;
    mv = 2'b00;
    #1;
    chk("t1_busy_after", 32'(busy), 32'h0);
    chk("t1_ready_after", 32'(m_ready), 32'h0);
    chk("t1_grant_after", 32'(grant), 32'h0);

    // Contention: both masters keep re-requesting, grants alternate from master 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    mv = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      exp2 = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      mv = 2'b11;
      srdy = 1'b1;
      srd = 32'(i);
      #1;
      chk($sformatf("t2_grant%0d", i), 32'(grant), 32'(exp2));
      chk($sformatf("t2_ready%0d", i), 32'(m_ready), 32'(exp2));
      if (m_ready == 2'b01) cnt0++;
      if (m_ready == 2'b10) cnt1++;
      step();
      srdy = 1'b0;
      mv = 2'b11 & ~exp2;
      #1;
      chk($sformatf("t2_idle%0d", i), 32'(busy), 32'h0);
    end
    mv = 2'b00;
    chk("t2_cnt0", 32'(cnt0), 32'd4);
    chk("t2_cnt1", 32'(cnt1), 32'd4);

    // Write passthrough from master 1; master 0 inputs must not leak.
    mv = 2'b10;
    ma = {32'h0300_0004, 32'h1111_1111};
    mw = {32'hA5A5_0000, 32'h2222_2222};
    ms = {4'b1100, 4'b1111};
    #1;
    chk("t3_idle_svalid", 32'(s_valid), 32'h0);
    step();
    #1;
    chk("t3_grant", 32'(grant), 32'h2);
    chk("t3_svalid", 32'(s_valid), 32'h1);
    chk("t3_saddr", s_addr, 32'h0300_0004);
    chk("t3_swdata", s_wdata, 32'hA5A5_0000);
    chk("t3_swstrb", 32'(s_wstrb), 32'hC);
    step();
    mv = 2'b11;
    #1;
    chk("t3_saddr_m0req", s_addr, 32'h0300_0004);
    chk("t3_ready0_none", 32'(m_ready), 32'h0);
    step();
    srdy = 1'b1;
    #1;
    chk("t3_ready", 32'(m_ready), 32'h2);
    step();
    srdy = 1'b0;
    mv = 2'b00;
    ma = '0;
    mw = '0;
    ms = '0;

    // Watchdog: slave never answers, forced completion on the 16th BUSY cycle.
    mv = 2'b01;
    ma[31:0] = 32'h0000_0100;
    step();
    for (int c = 1; c <= 15; c++) begin
      #1;
      chk($sformatf("t4_wait%0d", c), 32'({tmo, m_ready}), 32'h0);
      step();
    end
    #1;
    chk("t4_to_ready", 32'(m_ready), 32'h1);
    chk("t4_to_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("t4_to_pulse", 32'(tmo), 32'h1);
    step();
    mv = 2'b00;
    #1;
    chk("t4_to_gone", 32'(tmo), 32'h0);
    chk("t4_idle", 32'(busy), 32'h0);
    mv = 2'b01;
    step();
    srdy = 1'b1;
    srd = 32'hCAFE_0001;
    #1;
    chk("t4_next_ready", 32'(m_ready), 32'h1);
    chk("t4_next_rdata", m_rdata, 32'hCAFE_0001);
    chk("t4_next_noto", 32'(tmo), 32'h0);
    step();
    srdy = 1'b0;
    mv = 2'b00;

    // Watchdog race: slave ready exactly in the 16th cycle wins.
    #1;
    mv = 2'b01;
    step();
    for (int c = 1; c <= 15; c++) step();
    srdy = 1'b1;
    srd = 32'h5555_AAAA;
    #1;
    chk("t5_ready", 32'(m_ready), 32'h1);
    chk("t5_rdata", m_rdata, 32'h5555_AAAA);
    chk("t5_noto", 32'(tmo), 32'h0);
    step();
    srdy = 1'b0;
    mv = 2'b00;
    #1;
    chk("t5_idle", 32'(busy), 32'h0);

    // Reset in BUSY: ptr=0 so master 1 wins first; after reset master 0 must win.
    mv = 2'b11;
    step();
    #1;
    chk("t6_pre_grant", 32'(grant), 32'h2);
    step();
    rst = 1'b1;
    srdy = 1'b1;
    srd = 32'h7777_7777;
    #1;
    chk("t6_rst_noready", 32'(m_ready), 32'h0);
    step();
    rst = 1'b0;
    srdy = 1'b0;
    #1;
    chk("t6_post_grant", 32'(grant), 32'h0);
    chk("t6_post_busy", 32'(busy), 32'h0);
    chk("t6_post_svalid", 32'(s_valid), 32'h0);
    chk("t6_post_ready", 32'(m_ready), 32'h0);
    chk("t6_post_rdata", m_rdata, 32'h0);
    chk("t6_post_to", 32'(tmo), 32'h0);
    step();
    #1;
    chk("t6_first_grant", 32'(grant), 32'h1);
    srdy = 1'b1;
    #1;
    chk("t6_ready", 32'(m_ready), 32'h1);
    step();
    srdy = 1'b0;
    mv = 2'b00;

    // Three masters all requesting: wrap at a non-power-of-two count.
    rst = 1'b1;
    step();
    rst = 1'b0;
    mv3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      exp3 = 3'b001 << (i % 3);
      step();
      mv3 = 3'b111;
      srdy3 = 1'b1;
      srd3 = 32'h100 + 32'(i);
      #1;
      chk($sformatf("t7_grant%0d", i), 32'(grant3), 32'(exp3));
      chk($sformatf("t7_ready%0d", i), 32'(m_ready3), 32'(exp3));
      chk($sformatf("t7_rdata%0d", i), m_rdata3, 32'h100 + 32'(i));
      step();
      srdy3 = 1'b0;
      mv3 = 3'b111 & ~exp3;
      #1;
    end
    mv3 = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
